multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32 control FSM sequencing fetch/decode/exec/mem/wb.
// Define CTRL_MEM_TIMEOUT_EN to trap when a data access waits TIMEOUT_CYCLES cycles without mem_ack.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ack,
    output logic        ir_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  imm_sel,
    output logic [2:0]  state_o,
    output logic        trap,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  opcode_q;
    logic [31:0] instret_q;
    logic        run_q;
    logic [2:0]  imm_dec;
    logic        legal;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        timeout;
    logic [24:0] unused_instr_hi;

    assign unused_instr_hi = instr[31:7];

    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_branch = (opcode_q == OP_BRANCH);
    assign is_jump   = (opcode_q == OP_JAL) || (opcode_q == OP_JALR);

    always_comb begin
        imm_dec = 3'd7;
        legal   = 1'b1;
        case (opcode_q)
            OP_OPIMM, OP_LOAD, OP_JALR: imm_dec = 3'd0;
            OP_STORE:                   imm_dec = 3'd1;
            OP_BRANCH:                  imm_dec = 3'd2;
            OP_LUI, OP_AUIPC:           imm_dec = 3'd3;
            OP_JAL:                     imm_dec = 3'd4;
            OP_OP:                      imm_dec = 3'd7;
            default: begin
                imm_dec = 3'd7;
                legal   = 1'b0;
            end
        endcase
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    logic [7:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 8'd0;
        end else if ((state_q == ST_MEM) && !mem_ack) begin
            wait_q <= wait_q + 8'd1;
        end else begin
            wait_q <= 8'd0;
        end
    end

    // An ack arriving on the last allowed cycle still completes the access.
    assign timeout = (state_q == ST_MEM) && !mem_ack &&
                     (wait_q == 8'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opcode_q  <= 7'd0;
            instret_q <= 32'd0;
            run_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (ir_we) begin
                opcode_q <= instr[6:0];
            end
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // run_q keeps instr_req low while reset is held and releases it on the first edge after.
    always_comb begin
        state_d   = state_q;
        instr_req = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        trap      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_req = run_q;
                if (run_q && instr_valid) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_rd = is_load;
                mem_wr = is_store;
                if (mem_ack) begin
                    if (is_load) begin
                        state_d = ST_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = is_jump;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imm_sel = (state_q == ST_FETCH) ? 3'd7 : imm_dec;
    assign state_o = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_req;
    logic        instr_valid;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ack;
    logic        ir_we;
    logic        reg_we;
    logic        pc_we;
    logic        pc_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  imm_sel;
    logic [2:0]  state_o;
    logic        trap;
    logic [31:0] instret;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_req    (instr_req),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .branch_taken (branch_taken),
        .mem_ack      (mem_ack),
        .ir_we        (ir_we),
        .reg_we       (reg_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .imm_sel      (imm_sel),
        .state_o      (state_o),
        .trap         (trap),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        bt;
        int          fdly;
        int          adly;
        logic        noise;
        logic [31:0] trace;
        int          cycles;
        logic [2:0]  imm;
        int          nir;
        int          nreg;
        int          npc;
        logic        psel;
        int          nrd;
        int          nwr;
        logic        trapx;
    } vec_t;

    vec_t        vecs[$];
    int          total;
    int          bad;
    logic [31:0] exp_instret;

    logic [31:0] obs_trace;
    int          obs_cycles;
    logic [2:0]  obs_imm;
    logic        imm_bad;
    int          n_ir, n_reg, n_pc, n_rd, n_wr;
    logic        obs_psel;
    logic        obs_trap;
    logic        trap_strobe;
    logic        run_done;

    wire [6:0] strobes = {instr_req, ir_we, reg_we, pc_we, pc_sel, mem_rd, mem_wr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] ins, input logic bt, input int fdly, input int adly,
                       input logic noise, input logic [31:0] trace, input int cycles,
                       input logic [2:0] imm, input int nreg, input int npc, input logic psel,
                       input int nrd, input int nwr, input logic trapx);
        vec_t v;
        v.ins = ins; v.bt = bt; v.fdly = fdly; v.adly = adly; v.noise = noise;
        v.trace = trace; v.cycles = cycles; v.imm = imm; v.nir = 1; v.nreg = nreg;
        v.npc = npc; v.psel = psel; v.nrd = nrd; v.nwr = nwr; v.trapx = trapx;
        vecs.push_back(v);
    endtask

    task automatic run_one(input vec_t v);
        logic [2:0] st;
        int fcnt, mcnt;
        logic left;
        obs_trace = 0; obs_cycles = 0; obs_imm = 3'd7; imm_bad = 1'b0;
        n_ir = 0; n_reg = 0; n_pc = 0; n_rd = 0; n_wr = 0;
        obs_psel = 1'b0; obs_trap = 1'b0; trap_strobe = 1'b0; run_done = 1'b0;
        fcnt = 0; mcnt = 0; left = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            st = state_o;
            if (left && st == 3'd0) begin
                run_done = 1'b1;
                break;
            end
            instr        = v.ins;
            branch_taken = v.bt;
            instr_valid  = (st == 3'd0) ? (fcnt >= v.fdly) : v.noise;
            mem_ack      = (st == 3'd3) ? (v.adly >= 0 && mcnt == v.adly) : v.noise;
            #1;
            obs_trace = {obs_trace[27:0], 1'b0, st};
            obs_cycles++;
            if (ir_we)  n_ir++;
            if (reg_we) n_reg++;
            if (mem_rd) n_rd++;
            if (mem_wr) n_wr++;
            if (pc_we) begin
                n_pc++;
                obs_psel = pc_sel;
            end
            if (st == 3'd0) begin
                fcnt++;
                if (imm_sel !== 3'd7) imm_bad = 1'b1;
            end else begin
                left = 1'b1;
                if (st == 3'd1) obs_imm = imm_sel;
                else if (imm_sel !== obs_imm) imm_bad = 1'b1;
            end
            if (st == 3'd3) mcnt++;
            if (st == 3'd5) begin
                obs_trap    = trap;
                trap_strobe = (strobes != 7'd0);
                run_done    = 1'b1;
                break;
            end
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, " rst state"}, 32'(state_o), 32'd0);
        check({tag, " rst strobes"}, 32'(strobes), 32'd0);
        check({tag, " rst imm_sel"}, 32'(imm_sel), 32'd7);
        check({tag, " rst trap"}, 32'(trap), 32'd0);
        check({tag, " rst instret"}, instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " restart instr_req"}, 32'(instr_req), 32'd1);
        exp_instret = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; exp_instret = 0;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; branch_taken = 1'b0; mem_ack = 1'b0;

        //  instr         bt   f  ack noise trace          cyc imm reg pc psel rd wr trap
        add(32'h00500093, 1'b0, 0, 0, 1'b0, 32'h00000124,  4, 3'd0, 1, 1, 1'b0, 0, 0, 1'b0);
        add(32'h00208463, 1'b1, 0, 0, 1'b0, 32'h00000012,  3, 3'd2, 0, 1, 1'b1, 0, 0, 1'b0);
        add(32'h00208463, 1'b0, 0, 0, 1'b0, 32'h00000012,  3, 3'd2, 0, 1, 1'b0, 0, 0, 1'b0);
        add(32'h0000A103, 1'b0, 0, 3, 1'b0, 32'h01233334,  8, 3'd0, 1, 1, 1'b0, 4, 0, 1'b0);
        add(32'h0000A103, 1'b0, 0, 0, 1'b0, 32'h00001234,  5, 3'd0, 1, 1, 1'b0, 1, 0, 1'b0);
        add(32'h00112023, 1'b0, 0, 0, 1'b0, 32'h00000123,  4, 3'd1, 0, 1, 1'b0, 0, 1, 1'b0);
        add(32'h00112023, 1'b0, 0, 3, 1'b0, 32'h00123333,  7, 3'd1, 0, 1, 1'b0, 0, 4, 1'b0);
        add(32'h008000EF, 1'b0, 0, 0, 1'b0, 32'h00000124,  4, 3'd4, 1, 1, 1'b1, 0, 0, 1'b0);
        add(32'h000080E7, 1'b0, 0, 0, 1'b0, 32'h00000124,  4, 3'd0, 1, 1, 1'b1, 0, 0, 1'b0);
        add(32'h123450B7, 1'b0, 0, 0, 1'b0, 32'h00000124,  4, 3'd3, 1, 1, 1'b0, 0, 0, 1'b0);
        add(32'h00000097, 1'b0, 0, 0, 1'b0, 32'h00000124,  4, 3'd3, 1, 1, 1'b0, 0, 0, 1'b0);
        add(32'h002081B3, 1'b0, 0, 0, 1'b0, 32'h00000124,  4, 3'd7, 1, 1, 1'b0, 0, 0, 1'b0);
        add(32'h00500093, 1'b0, 2, 0, 1'b0, 32'h00000124,  6, 3'd0, 1, 1, 1'b0, 0, 0, 1'b0);
        add(32'h0000A103, 1'b0, 0, 2, 1'b1, 32'h00123334,  7, 3'd0, 1, 1, 1'b0, 3, 0, 1'b0);
`ifdef CTRL_MEM_TIMEOUT_EN
        add(32'h00112023, 1'b0, 0, -1, 1'b0, 32'h01233335, 8, 3'd1, 0, 0, 1'b0, 0, 4, 1'b1);
`else
        add(32'h00112023, 1'b0, 0, 6, 1'b0, 32'h23333333, 10, 3'd1, 0, 1, 1'b0, 0, 7, 1'b0);
`endif
        add(32'h0000007F, 1'b0, 0, 0, 1'b0, 32'h00000015,  3, 3'd7, 0, 0, 1'b0, 0, 0, 1'b1);
        add(32'h00000010, 1'b0, 0, 0, 1'b1, 32'h00000015,  3, 3'd7, 0, 0, 1'b0, 0, 0, 1'b1);
        add(32'h00500093, 1'b0, 0, 0, 1'b0, 32'h00000124,  4, 3'd0, 1, 1, 1'b0, 0, 0, 1'b0);

        #3;
        check("reset state", 32'(state_o), 32'd0);
        check("reset strobes", 32'(strobes), 32'd0);
        check("reset imm_sel", 32'(imm_sel), 32'd7);
        check("reset trap", 32'(trap), 32'd0);
        check("reset instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first edge instr_req", 32'(instr_req), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            run_one(vecs[i]);
            check({tag, " done"}, 32'(run_done), 32'd1);
            check({tag, " trace"}, obs_trace, vecs[i].trace);
            check({tag, " cycles"}, 32'(obs_cycles), 32'(vecs[i].cycles));
            check({tag, " imm_sel"}, 32'(obs_imm), 32'(vecs[i].imm));
            check({tag, " imm_stable"}, 32'(imm_bad), 32'd0);
            check({tag, " ir_we"}, 32'(n_ir), 32'(vecs[i].nir));
            check({tag, " reg_we"}, 32'(n_reg), 32'(vecs[i].nreg));
            check({tag, " pc_we"}, 32'(n_pc), 32'(vecs[i].npc));
            check({tag, " pc_sel"}, 32'(obs_psel), 32'(vecs[i].psel));
            check({tag, " mem_rd"}, 32'(n_rd), 32'(vecs[i].nrd));
            check({tag, " mem_wr"}, 32'(n_wr), 32'(vecs[i].nwr));
            check({tag, " trap"}, 32'(obs_trap), 32'(vecs[i].trapx));
            exp_instret = exp_instret + 32'(vecs[i].npc);
            check({tag, " instret"}, instret, exp_instret);
            if (vecs[i].trapx) begin
                logic held;
                check({tag, " trap strobes"}, 32'(trap_strobe), 32'd0);
                held = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    instr_valid = 1'b1;
                    mem_ack     = 1'b1;
                    #1;
                    if (state_o !== 3'd5 || trap !== 1'b1 || strobes !== 7'd0) held = 1'b0;
                end
                instr_valid = 1'b0;
                mem_ack     = 1'b0;
                check({tag, " trap held"}, 32'(held), 32'd1);
                reset_pulse(tag);
            end
        end

        begin
            logic reached;
            reached = 1'b0;
            instr = 32'h00112023;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                instr_valid = (state_o == 3'd0);
                mem_ack     = 1'b0;
                if (state_o == 3'd3) begin
                    reached = 1'b1;
                    break;
                end
            end
            instr_valid = 1'b0;
            check("midmem reached", 32'(reached), 32'd1);
            #1;
            check("midmem mem_wr", 32'(mem_wr), 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            check("midmem async mem_wr", 32'(mem_wr), 32'd0);
            check("midmem async state", 32'(state_o), 32'd0);
            check("midmem instret", instret, 32'd0);
            check("midmem instr_req", 32'(instr_req), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("midmem restart req", 32'(instr_req), 32'd1);
            check("midmem restart state", 32'(state_o), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
